// File: rtl/aukv_dmem_resp_if.sv
// Data-memory request/response bundle between the core's memory stage
// (master) and the data-memory responder (slave).
//
// Handshake: the master raises i_mem_en with a stable request for at least
// one rising edge; the slave accepts it on the first edge it sees i_mem_en
// in IDLE and ignores i_mem_en until it is back in IDLE. Completion is a
// single-cycle o_mem_valid pulse with o_mem_err and o_mem_data qualified by it.
// There is no ready: the master is told to back off via o_mem_busy and must
// leave at least LATENCY+2 cycles between request acceptances.
interface aukv_dmem_resp_if;
  logic        i_mem_en;
  logic        i_mem_we;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_data;
  logic [3:0]  i_mem_strobe;
  logic [31:0] o_mem_data;
  logic        o_mem_valid;
  logic        o_mem_busy;
  logic        o_mem_err;

  modport master (
    output i_mem_en, i_mem_we, i_mem_addr, i_mem_data, i_mem_strobe,
    input  o_mem_data, o_mem_valid, o_mem_busy, o_mem_err
  );

  modport slave (
    input  i_mem_en, i_mem_we, i_mem_addr, i_mem_data, i_mem_strobe,
    output o_mem_data, o_mem_valid, o_mem_busy, o_mem_err
  );
endinterface

// File: rtl/aukv_dmem_resp.sv
// Data-memory responder: word-organised byte-addressable RAM that answers
// each accepted request with a one-cycle valid LATENCY cycles later.
// Low-aligned write data and strobes are moved onto byte lanes by addr[1:0];
// read data is shifted back down to bit 0, zero-filled from the top.
module aukv_dmem_resp #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  aukv_dmem_resp_if.slave   io_mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  // Storage is never reset; contents survive i_rst.
  logic [31:0]       r_mem [DEPTH];

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_strobe;
  logic              r_valid;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_off;
  logic [4:0]        w_bit_off;
  logic              w_oor;
  logic [6:0]        w_sh_strobe;
  logic [3:0]        w_eff_strobe;
  logic              w_mis;
  logic [31:0]       w_eff_wdata;
  logic [31:0]       w_rword;
  logic [31:0]       w_rdata;
  logic              w_access;
  logic              w_commit;

  // Decode of the latched request; only latched values drive the access.
  assign w_idx        = r_addr[ADDR_W+1:2];
  assign w_off        = r_addr[1:0];
  assign w_bit_off    = {w_off, 3'b000};
  assign w_oor        = |r_addr[31:ADDR_W+2];
  assign w_sh_strobe  = {3'b000, r_strobe} << w_off;
  assign w_eff_strobe = w_sh_strobe[3:0];
  assign w_mis        = |w_sh_strobe[6:4];
  assign w_eff_wdata  = r_wdata << w_bit_off;
  assign w_rword      = r_mem[w_idx];
  assign w_rdata      = w_rword >> w_bit_off;

  // The access edge is the WAIT edge with the counter exhausted; a reset on
  // that same edge aborts it, so nothing is committed.
  assign w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_commit = w_access && !i_rst && r_we && !w_oor;

  // Byte-lane write into the array on the access edge of an in-range write.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_eff_strobe[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_eff_wdata[8*b +: 8];
        end
      end
    end
  end

  // Request FSM: accept in IDLE, count down in WAIT, pulse valid in RESP,
  // then one GAP cycle that swallows the core's late en de-assertion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_strobe <= 4'd0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_mem.i_mem_en) begin
            r_we     <= io_mem.i_mem_we;
            r_addr   <= io_mem.i_mem_addr;
            r_wdata  <= io_mem.i_mem_data;
            r_strobe <= io_mem.i_mem_strobe;
            r_cnt    <= CNT_INIT;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_access) begin
            r_valid <= 1'b1;
            r_err   <= w_oor | w_mis;
            // Writes and out-of-range reads answer with zero data.
            r_rdata <= (r_we || w_oor) ? 32'd0 : w_rdata;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: r_state <= ST_GAP;
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_mem.o_mem_data  = r_rdata;
  assign io_mem.o_mem_valid = r_valid;
  assign io_mem.o_mem_err   = r_err;
  assign io_mem.o_mem_busy  = (r_state != ST_IDLE);

endmodule
